// File: rtl/gate_stim_checker.sv
// LFSR stimulus generator and golden-value checker for the mux_2x1 / xor_gate / xnor_gate cells.
// Optional build macro GATE_CHK_HALT_ON_ERR_EN: stop the run on the first mismatching vector.
module gate_stim_checker #(
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
  parameter int                NUM_VECTORS   = 20,
  parameter int                SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        in_a,
  output logic        in_b,
  output logic        sel,
  input  logic        out_mux,
  input  logic        out_xor,
  input  logic        out_xnor,
  output logic [15:0] vec_cnt,
  output logic [15:0] err_cnt,
  output logic        err_flag,
  output logic [2:0]  err_vec
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  localparam logic [LFSR_W-1:0] SEED_EFF    = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [16:0]       NUM_VEC_L   = 17'(NUM_VECTORS);
  localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

`ifdef GATE_CHK_HALT_ON_ERR_EN
  localparam bit HALT_ON_ERR = 1'b1;
`else
  localparam bit HALT_ON_ERR = 1'b0;
`endif

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [7:0]        settle_cnt;
  logic              exp_mux;
  logic              exp_xor;
  logic              exp_xnor;
  logic [2:0]        mis;
  logic              last_vec;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[LFSR_W-2:0], fb};
  endfunction

  // Case inequality so that X or Z from a broken cell counts as a failure.
  always_comb begin
    exp_mux  = sel ? in_b : in_a;
    exp_xor  = in_a ^ in_b;
    exp_xnor = ~(in_a ^ in_b);
    mis[2]   = (out_mux  !== exp_mux);
    mis[1]   = (out_xor  !== exp_xor);
    mis[0]   = (out_xnor !== exp_xnor);
    last_vec = (({1'b0, vec_cnt} + 17'd1) == NUM_VEC_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED_EFF;
      settle_cnt <= '0;
      in_a       <= 1'b0;
      in_b       <= 1'b0;
      sel        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      err_flag   <= 1'b0;
      err_vec    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr     <= SEED_EFF;
            vec_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            err_vec  <= '0;
            if (NUM_VECTORS == 0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_DRIVE;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        S_DRIVE: begin
          in_a       <= lfsr[0];
          in_b       <= lfsr[1];
          sel        <= lfsr[2];
          lfsr       <= lfsr_step(lfsr);
          settle_cnt <= SETTLE_LOAD;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == 8'd0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_CHECK: begin
          vec_cnt <= sat_inc(vec_cnt);
          if (|mis) begin
            err_cnt  <= sat_inc(err_cnt);
            err_flag <= 1'b1;
            err_vec  <= mis;
          end
          if (last_vec || (HALT_ON_ERR && (|mis))) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_DRIVE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
